// File: rtl/pipe_pkg.sv
// Shared widths and the occupancy encoding for the elastic pipeline-stage register.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipe_pkg;

    localparam int DATA_W_DEF = 192;
    localparam int CTRL_W_DEF = 12;
    localparam int CNT_W_DEF  = 16;

    // Occupancy of the stage: nothing held, main slot held, main and skid slots held.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_slot.sv
// One valid+payload storage slot; clear wins over load and zeroes the payload.
// Latency: 1 cycle from load to visible contents.
// Backpressure: none here; the parent decides when to load or clear.
module pipe_slot #(
    parameter int DATA_W = 192,
    parameter int CTRL_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] d_data,
    input  logic [CTRL_W-1:0] d_ctrl,
    output logic              valid,
    output logic [DATA_W-1:0] data,
    output logic [CTRL_W-1:0] ctrl
);

    // Empty slots always hold zero so a bubble never carries stale control bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            data  <= '0;
            ctrl  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= d_data;
            ctrl  <= d_ctrl;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic inter-stage register with flush and a saturating bubble counter; PIPE_SKID_EN adds a skid slot.
// Latency: 1 cycle from input transfer to out_valid when empty; one transfer per cycle sustained.
// Backpressure: base build in_ready = !out_valid || out_ready (combinational); skid build in_ready = !skid_valid (registered).
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [CNT_W-1:0]  bubble_cnt
);

    pipe_state_t       state;
    logic              in_xfer;
    logic              main_vld;
    logic [DATA_W-1:0] main_dat;
    logic [CTRL_W-1:0] main_ctl;
    logic              main_load;
    logic              main_clear;
    logic [DATA_W-1:0] main_d_dat;
    logic [CTRL_W-1:0] main_d_ctl;

    assign in_xfer = in_valid && in_ready;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_main (
        .clk    (clk),
        .reset  (reset),
        .load   (main_load),
        .clear  (main_clear),
        .d_data (main_d_dat),
        .d_ctrl (main_d_ctl),
        .valid  (main_vld),
        .data   (main_dat),
        .ctrl   (main_ctl)
    );

`ifdef PIPE_SKID_EN
    logic              skid_vld;
    logic [DATA_W-1:0] skid_dat;
    logic [CTRL_W-1:0] skid_ctl;
    logic              skid_load;
    logic              skid_clear;

    pipe_slot #(
        .DATA_W (DATA_W),
        .CTRL_W (CTRL_W)
    ) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load),
        .clear  (skid_clear),
        .d_data (in_data),
        .d_ctrl (in_ctrl),
        .valid  (skid_vld),
        .data   (skid_dat),
        .ctrl   (skid_ctl)
    );

    // Registered ready: only the skid occupancy gates the upstream stage.
    assign in_ready = !skid_vld;

    // Occupancy decode from the slot valid bits.
    always_comb begin
        state = EMPTY;
        if (skid_vld) begin
            state = SKID;
        end else if (main_vld) begin
            state = FULL;
        end
    end

    // Slot control: flush first, then drain skid into main, else accept into main or skid.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        main_d_dat = in_data;
        main_d_ctl = in_ctrl;
        if (flush) begin
            main_clear = 1'b1;
            skid_clear = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    main_load = in_xfer;
                end
                FULL: begin
                    if (out_ready) begin
                        main_load  = in_xfer;
                        main_clear = !in_xfer;
                    end else begin
                        skid_load = in_xfer;
                    end
                end
                SKID: begin
                    // in_ready is low here, so no new input competes with the skid entry.
                    if (out_ready) begin
                        main_load  = 1'b1;
                        main_d_dat = skid_dat;
                        main_d_ctl = skid_ctl;
                        skid_clear = 1'b1;
                    end
                end
                default: begin
                    main_clear = 1'b1;
                    skid_clear = 1'b1;
                end
            endcase
        end
    end
`else
    // Ready whenever the held entry is leaving or nothing is held.
    assign in_ready = !main_vld || out_ready;

    // Occupancy decode from the main slot valid bit.
    always_comb begin
        state = main_vld ? FULL : EMPTY;
    end

    // Slot control: flush first, then load on accept or clear on a pure drain.
    always_comb begin
        main_load  = 1'b0;
        main_clear = 1'b0;
        main_d_dat = in_data;
        main_d_ctl = in_ctrl;
        if (flush) begin
            main_clear = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    main_load = in_xfer;
                end
                FULL: begin
                    main_load  = in_xfer;
                    main_clear = out_ready && !in_xfer;
                end
                default: begin
                    main_clear = 1'b1;
                end
            endcase
        end
    end
`endif

    assign out_valid = main_vld;
    assign out_data  = main_dat;
    assign out_ctrl  = main_ctl;

    // Count cycles with no valid output, holding at all-ones; flush does not clear it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (!main_vld && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg with a queue scoreboard and an independent output monitor.
// Latency: checks 1-cycle fill latency and back-to-back throughput.
// Backpressure: checks stall stability, in_ready behaviour for base and PIPE_SKID_EN builds, and flush drops.
module tb_pipe_stage_reg;

    localparam int DW = 192;
    localparam int CW = 12;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [CW-1:0] c;
    } item_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic [CW-1:0] in_ctrl;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [CW-1:0] out_ctrl;
    logic [15:0]   bubble_cnt;

    // Second instance with a 4-bit counter, left idle to observe saturation.
    logic          flush4    = 1'b0;
    logic          in_valid4 = 1'b0;
    logic          in_ready4;
    logic [DW-1:0] in_data4  = '0;
    logic [CW-1:0] in_ctrl4  = '0;
    logic          out_valid4;
    logic          out_ready4 = 1'b1;
    logic [DW-1:0] out_data4;
    logic [CW-1:0] out_ctrl4;
    logic [3:0]    bubble4;

    int    n_chk  = 0;
    int    n_fail = 0;
    item_t sb[$];
    item_t exp_item;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_ctrl    (in_ctrl),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ctrl   (out_ctrl),
        .bubble_cnt (bubble_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush4),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .in_data    (in_data4),
        .in_ctrl    (in_ctrl4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready4),
        .out_data   (out_data4),
        .out_ctrl   (out_ctrl4),
        .bubble_cnt (bubble4)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Input side: every accepted, non-flushed transfer is expected at the output unchanged.
    always @(negedge clk) begin
        if (!reset && in_valid && in_ready && !flush) begin
            sb.push_back({in_data, in_ctrl});
        end
    end

    // Output side: compare every output transfer against the queue head; flush discards held entries.
    always @(negedge clk) begin
        if (!reset) begin
            if (!out_valid) begin
                check("bubble_ctrl_zero", 256'(out_ctrl), 256'(0));
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_output: got data %0h ctrl %0h, want no transfer", out_data, out_ctrl);
                end else begin
                    exp_item = sb.pop_front();
                    check("sb_out_data", 256'(out_data), 256'(exp_item.d));
                    check("sb_out_ctrl", 256'(out_ctrl), 256'(exp_item.c));
                end
            end
            if (flush) begin
                sb.delete();
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_ctrl   = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_out_data", 256'(out_data), 256'(0));
        check("rst_out_ctrl", 256'(out_ctrl), 256'(0));
        check("rst_bubble_cnt", 256'(bubble_cnt), 256'(0));
        check("rst_in_ready", 256'(in_ready), 256'(1));
        reset = 1'b0;

        // Nine idle cycles plus the accepting cycle: ten bubble cycles before the output appears.
        repeat (9) step();
        in_valid  = 1'b1;
        in_data   = 192'h0BEEF;
        in_ctrl   = 12'h321;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check("first_out_valid", 256'(out_valid), 256'(1));
        check("bubble_at_first_out", 256'(bubble_cnt), 256'(10));
        check("cnt4_counting", 256'(bubble4), 256'(10));
        step();
        check("first_drained", 256'(out_valid), 256'(0));

        // Eight back-to-back transfers with downstream always ready.
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 192'h1234 | (192'(i) << 16);
            in_ctrl  = 12'hABC;
            @(negedge clk);
            check("stream_in_ready", 256'(in_ready), 256'(1));
            step();
            check("stream_no_gap", 256'(out_valid), 256'(1));
        end
        in_valid = 1'b0;
        step();
        check("stream_drained", 256'(out_valid), 256'(0));

        // Stall with 0x55 held for three cycles.
        in_valid  = 1'b1;
        in_data   = 192'h55;
        in_ctrl   = 12'h055;
        out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        check("stall_loaded", 256'(out_valid), 256'(1));
`ifdef PIPE_SKID_EN
        in_valid = 1'b1;
        in_data  = 192'h66;
        in_ctrl  = 12'h066;
        @(negedge clk);
        check("skid_accepts", 256'(in_ready), 256'(1));
        step();
        in_valid = 1'b0;
        check("skid_in_ready_low", 256'(in_ready), 256'(0));
        check("stall_data", 256'(out_data), 256'(192'h55));
        repeat (2) begin
            step();
            check("stall_data", 256'(out_data), 256'(192'h55));
            check("skid_hold_ready", 256'(in_ready), 256'(0));
        end
        out_ready = 1'b1;
        step();
        check("skid_second_valid", 256'(out_valid), 256'(1));
        check("skid_second_data", 256'(out_data), 256'(192'h66));
        check("skid_in_ready_back", 256'(in_ready), 256'(1));
        step();
        check("skid_drained", 256'(out_valid), 256'(0));
`else
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 256'(in_ready), 256'(0));
            step();
            check("stall_valid", 256'(out_valid), 256'(1));
            check("stall_data", 256'(out_data), 256'(192'h55));
            check("stall_ctrl", 256'(out_ctrl), 256'(12'h055));
        end
        out_ready = 1'b1;
        step();
        check("stall_drained", 256'(out_valid), 256'(0));
`endif
        check("cnt4_saturated", 256'(bubble4), 256'(15));

        // Flush while FULL and stalled, with a control-heavy input presented.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 192'h77;
        in_ctrl   = 12'h111;
        step();
        in_data = 192'h99;
        in_ctrl = 12'hFFF;
        flush   = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 256'(out_valid), 256'(0));
        check("flush_out_ctrl", 256'(out_ctrl), 256'(0));
        check("flush_out_data", 256'(out_data), 256'(0));
        out_ready = 1'b1;
        repeat (3) begin
            step();
            check("flush_no_late", 256'(out_valid), 256'(0));
        end

        // Flush while empty and ready: the accepted input is dropped.
        in_valid = 1'b1;
        in_data  = 192'h88;
        in_ctrl  = 12'hFFF;
        flush    = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_drop_valid", 256'(out_valid), 256'(0));
        step();
        check("flush_drop_late", 256'(out_valid), 256'(0));
        check("sb_empty", 256'(sb.size()), 256'(0));

        // Asynchronous reset in the middle of a cycle while FULL.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 192'hAA;
        in_ctrl   = 12'h0AA;
        step();
        in_valid = 1'b0;
        check("pre_reset_full", 256'(out_valid), 256'(1));
        #2;
        reset = 1'b1;
        sb.delete();
        #1;
        check("async_rst_valid", 256'(out_valid), 256'(0));
        check("async_rst_data", 256'(out_data), 256'(0));
        check("async_rst_ctrl", 256'(out_ctrl), 256'(0));
        check("async_rst_bubble", 256'(bubble_cnt), 256'(0));
        step();
        reset = 1'b0;
        step();
        check("post_rst_in_ready", 256'(in_ready), 256'(1));
        check("post_rst_count", 256'(bubble_cnt), 256'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
